adc_dac_frontend_model: RTL and testbench
=========================================

Name: adc_dac_frontend_model

Overview:
- Synthesizable single-clock converter front-end model for system-level simulation of the Red Pitaya top.
- ADC side: takes four signed sample streams, or an internal ramp pattern, and presents them to the DUT-facing ports in three formats: parallel left-justified, 7-bit half-word multiplexed, and pseudo-differential p/n.
- DAC side: decodes the top's interleaved or parallel DAC bus back into two signed channel values for checking.

Parameters:
- DW, 14, ADC sample width (12..16).
- PATTERN, 0, ADC source: 0 = adc_data_in*, 1 = internal ramp.
- RAMP_MIN, -1000, ramp lower bound (signed DW).
- RAMP_MAX, 1000, ramp upper bound (signed DW).
- DAC_MODE, 0, 0 = interleaved (single bus + select), 1 = parallel (two buses).

Ports:
- adc_clk_i  in  1  sole clock, rising edge.
- adc_rst_i  in  1  synchronous reset, active high.
- adc_data_in0..3  in  DW each  signed samples, channels 0..3.
- adc_drv_o  out  4x16  parallel samples, left-justified.
- adc_drv_ddr_o  out  4x7  half-word multiplexed samples.
- adc_drv_p_o  out  4x7  equal to adc_drv_ddr_o.
- adc_drv_n_o  out  4x7  bitwise inverse of adc_drv_p_o.
- adc_frame_o  out  1  high while adc_drv_ddr_o carries the upper half.
- dac_dat_i  in  2x14  DAC bus(es) from the top; [0] is the interleaved bus.
- dac_wrt_i  in  1  DAC write strobe.
- dac_sel_i  in  1  interleave select: 1 = channel A, 0 = channel B.
- dac_clk_i  in  1  DAC clock level, used as a qualifier.
- dac_rst_i  in  1  DAC reset from the top.
- dac_a_o  out  14  decoded channel A, signed.
- dac_b_o  out  14  decoded channel B, signed.

Behaviour:
Reset (adc_rst_i = 1 at a rising edge):
- All outputs 0 except adc_drv_n_o = all ones.
- Ramp registers load RAMP_MIN + 250*ch for ch = 0..3.
- Phase register is cleared.

Sample source:
- PATTERN = 0: channel sample = adc_data_inN.
- PATTERN = 1: each channel ramp increments by 1 per cycle.
- Ramp wrap: when the value is >= RAMP_MAX, the next value is RAMP_MIN. It is never outside [RAMP_MIN, RAMP_MAX] after reset.

Parallel path:
- adc_drv_o[ch][15:16-DW] = sample; remaining low bits are 0.
- Registered, one-cycle latency from adc_data_in.

Half-word path:
- The 14-bit word W = adc_drv_o[ch][15:2].
- Phase toggles every cycle.
- Phase 0: adc_drv_ddr_o[ch] = W[6:0] and adc_frame_o = 0. W is captured from the current parallel register on this phase.
- Phase 1: adc_drv_ddr_o[ch] = W[13:7] (same captured word) and adc_frame_o = 1.
- Effective half-word sample rate is clk/2.
- adc_drv_p_o = adc_drv_ddr_o and adc_drv_n_o = ~adc_drv_ddr_o, in the same cycle with no skew.

DAC decode:
- Conversion: offset binary to two's complement (invert bit 13) before storing.
- Write strobe wr = dac_wrt_i & dac_clk_i, sampled at the rising edge.
- DAC_MODE = 0, wr = 1: dac_sel_i = 1 stores dac_dat_i[0] into A; dac_sel_i = 0 stores it into B.
- DAC_MODE = 1: A <= dac_dat_i[0] and B <= dac_dat_i[1] every cycle; dac_wrt_i and dac_sel_i are ignored.
- dac_rst_i = 1 clears A and B to 0 and overrides any write in the same cycle.
- Latency is one cycle; both outputs hold their value between writes.
- Reset mid-stream: all state is cleared; the first valid half-word pair starts with phase 0 on the second edge after reset is released.

Test Plan:
- Reset check: hold adc_rst_i for 4 cycles -> adc_drv_o = 0, adc_drv_n_o = 7'h7F, dac_a_o = dac_b_o = 0.
- Parallel path: PATTERN = 0, DW = 14, adc_data_in0 = -1000 (14'h3C18) -> one cycle later adc_drv_o[0] = 16'hF060.
- Ramp wrap: PATTERN = 1 -> channel 0 counts -1000, -999, ..., 1000, then -1000 on the next cycle; channel 1 starts at -750.
- Half-word path: adc_drv_o[1] = 16'hABCC, so W = 14'h2AF3 -> phase 0 gives ddr = 7'h73 with frame = 0; phase 1 gives ddr = 7'h55 with frame = 1; n = ~p in both phases.
- DAC interleave: DAC_MODE = 0, wr = 1, sel = 1 with data 14'h2000, then sel = 0 with data 14'h0000 -> dac_a_o = 0, dac_b_o = 14'h2000 (-8192).
- DAC reset priority: dac_rst_i = 1 together with a valid write -> both outputs 0; a write with dac_clk_i = 0 -> outputs unchanged.

Source files
------------

// File: rtl/adc_dac_frontend_model.sv
// Converter front-end model for system-level simulation of the Red Pitaya top.
// The ADC side drives four sample streams (external or ramp) as parallel,
// 7-bit half-word multiplexed and pseudo-differential outputs. The DAC side
// decodes the top's offset-binary DAC bus back into two signed channel values.
module adc_dac_frontend_model #(
  parameter int DW       = 14,
  parameter int PATTERN  = 0,
  parameter int RAMP_MIN = -1000,
  parameter int RAMP_MAX = 1000,
  parameter int DAC_MODE = 0
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rst_i,
  input  logic signed [DW-1:0]  adc_data_in0,
  input  logic signed [DW-1:0]  adc_data_in1,
  input  logic signed [DW-1:0]  adc_data_in2,
  input  logic signed [DW-1:0]  adc_data_in3,
  output logic [3:0][15:0]      adc_drv_o,
  output logic [3:0][6:0]       adc_drv_ddr_o,
  output logic [3:0][6:0]       adc_drv_p_o,
  output logic [3:0][6:0]       adc_drv_n_o,
  output logic                  adc_frame_o,
  input  logic [1:0][13:0]      dac_dat_i,
  input  logic                  dac_wrt_i,
  input  logic                  dac_sel_i,
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  output logic signed [13:0]    dac_a_o,
  output logic signed [13:0]    dac_b_o
);

  localparam logic signed [DW-1:0] RMIN     = DW'(RAMP_MIN);
  localparam logic signed [DW-1:0] RMAX     = DW'(RAMP_MAX);
  localparam logic signed [DW-1:0] RAMP_ONE = DW'(1);

  // Ramp start value per channel; a start beyond the upper bound falls back
  // to the lower bound so the ramp never leaves its range.
  function automatic logic signed [DW-1:0] ramp_init(input int ch);
    int v;
    v = RAMP_MIN + 250 * ch;
    if (v > RAMP_MAX) begin
      v = RAMP_MIN;
    end
    return DW'(v);
  endfunction

  logic signed [DW-1:0] data_in [4];
  logic signed [DW-1:0] sample  [4];
  logic signed [DW-1:0] ramp_q  [4];
  logic signed [DW-1:0] ramp_d  [4];
  logic [3:0][15:0]     par_q;
  logic [3:0][15:0]     par_d;
  logic [3:0][13:0]     word_q;
  logic [3:0][13:0]     word_d;
  logic                 phase_q;
  logic                 phase_d;
  logic signed [13:0]   dac_a_q;
  logic signed [13:0]   dac_a_d;
  logic signed [13:0]   dac_b_q;
  logic signed [13:0]   dac_b_d;
  logic                 dac_wr;
  logic [13:0]          dac_conv0;
  logic [13:0]          dac_conv1;

  // Pick the sample source and compute next ramp and parallel-register values.
  always_comb begin
    data_in[0] = adc_data_in0;
    data_in[1] = adc_data_in1;
    data_in[2] = adc_data_in2;
    data_in[3] = adc_data_in3;
    for (int ch = 0; ch < 4; ch++) begin
      sample[ch] = (PATTERN == 1) ? ramp_q[ch] : data_in[ch];
      if (ramp_q[ch] >= RMAX) begin
        ramp_d[ch] = RMIN;
      end else begin
        ramp_d[ch] = ramp_q[ch] + RAMP_ONE;
      end
      // Left-justify into 16 bits; the wide intermediate keeps DW = 16 legal.
      par_d[ch] = 16'({sample[ch], {(32-DW){1'b0}}} >> 16);
    end
  end

  // The word is captured on the edge that enters phase 0, so both halves
  // presented in a pair always come from the same parallel sample.
  always_comb begin
    phase_d = ~phase_q;
    word_d  = word_q;
    for (int ch = 0; ch < 4; ch++) begin
      if (phase_q) begin
        word_d[ch] = par_q[ch][15:2];
      end
    end
  end

  // DAC decode: offset binary to two's complement, reset wins over writes.
  always_comb begin
    dac_wr    = dac_wrt_i & dac_clk_i;
    dac_conv0 = {~dac_dat_i[0][13], dac_dat_i[0][12:0]};
    dac_conv1 = {~dac_dat_i[1][13], dac_dat_i[1][12:0]};
    dac_a_d   = dac_a_q;
    dac_b_d   = dac_b_q;
    if (dac_rst_i) begin
      dac_a_d = '0;
      dac_b_d = '0;
    end else if (DAC_MODE == 1) begin
      dac_a_d = dac_conv0;
      dac_b_d = dac_conv1;
    end else if (dac_wr) begin
      if (dac_sel_i) begin
        dac_a_d = dac_conv0;
      end else begin
        dac_b_d = dac_conv0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      for (int ch = 0; ch < 4; ch++) begin
        ramp_q[ch] <= ramp_init(ch);
      end
      par_q   <= '0;
      word_q  <= '0;
      phase_q <= 1'b0;
      dac_a_q <= '0;
      dac_b_q <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        ramp_q[ch] <= ramp_d[ch];
      end
      par_q   <= par_d;
      word_q  <= word_d;
      phase_q <= phase_d;
      dac_a_q <= dac_a_d;
      dac_b_q <= dac_b_d;
    end
  end

  // Present the captured word low half in phase 0, high half in phase 1.
  always_comb begin
    adc_drv_o   = par_q;
    adc_frame_o = phase_q;
    for (int ch = 0; ch < 4; ch++) begin
      adc_drv_ddr_o[ch] = phase_q ? word_q[ch][13:7] : word_q[ch][6:0];
      adc_drv_p_o[ch]   = adc_drv_ddr_o[ch];
      adc_drv_n_o[ch]   = ~adc_drv_ddr_o[ch];
    end
    dac_a_o = dac_a_q;
    dac_b_o = dac_b_q;
  end

endmodule

// File: tb/tb_adc_dac_frontend_model.sv
// Scoreboard bench for adc_dac_frontend_model: one instance with external
// samples and interleaved DAC, one with ramp samples and parallel DAC.
module tb_adc_dac_frontend_model;

  typedef struct {
    int          due;
    string       name;
    int          sig;
    int          idx;
    logic [15:0] exp;
  } exp_t;

  localparam int S_DRV   = 0;
  localparam int S_DDR   = 1;
  localparam int S_P     = 2;
  localparam int S_N     = 3;
  localparam int S_FRAME = 4;
  localparam int S_DA    = 5;
  localparam int S_DB    = 6;
  localparam int S_RDRV  = 7;
  localparam int S_RDA   = 8;
  localparam int S_RDB   = 9;
  localparam int S_RN    = 10;

  logic clk = 1'b0;
  logic adc_rst;
  logic signed [13:0] din0, din1, din2, din3;
  logic [1:0][13:0] dac_dat;
  logic dac_wrt, dac_sel, dac_clk, dac_rst;

  logic [3:0][15:0] drv, rdrv;
  logic [3:0][6:0]  ddr, p, n, rddr, rp, rn;
  logic             frame, rframe;
  logic signed [13:0] da, db, rda, rdb;

  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_dac_frontend_model #(.DW(14), .PATTERN(0), .DAC_MODE(0)) dut (
    .adc_clk_i(clk), .adc_rst_i(adc_rst),
    .adc_data_in0(din0), .adc_data_in1(din1), .adc_data_in2(din2), .adc_data_in3(din3),
    .adc_drv_o(drv), .adc_drv_ddr_o(ddr), .adc_drv_p_o(p), .adc_drv_n_o(n),
    .adc_frame_o(frame),
    .dac_dat_i(dac_dat), .dac_wrt_i(dac_wrt), .dac_sel_i(dac_sel),
    .dac_clk_i(dac_clk), .dac_rst_i(dac_rst),
    .dac_a_o(da), .dac_b_o(db)
  );

  adc_dac_frontend_model #(.DW(14), .PATTERN(1), .DAC_MODE(1)) dut_ramp (
    .adc_clk_i(clk), .adc_rst_i(adc_rst),
    .adc_data_in0(din0), .adc_data_in1(din1), .adc_data_in2(din2), .adc_data_in3(din3),
    .adc_drv_o(rdrv), .adc_drv_ddr_o(rddr), .adc_drv_p_o(rp), .adc_drv_n_o(rn),
    .adc_frame_o(rframe),
    .dac_dat_i(dac_dat), .dac_wrt_i(dac_wrt), .dac_sel_i(dac_sel),
    .dac_clk_i(dac_clk), .dac_rst_i(dac_rst),
    .dac_a_o(rda), .dac_b_o(rdb)
  );

  // 14-bit signed value left-justified into the 16-bit parallel format.
  function automatic logic [15:0] lj(input int v);
    logic [13:0] t;
    t = 14'(v);
    return {t, 2'b00};
  endfunction

  function automatic logic [15:0] actual(input int sig, input int idx);
    case (sig)
      S_DRV:   return drv[idx];
      S_DDR:   return {9'd0, ddr[idx]};
      S_P:     return {9'd0, p[idx]};
      S_N:     return {9'd0, n[idx]};
      S_FRAME: return {15'd0, frame};
      S_DA:    return {2'd0, da};
      S_DB:    return {2'd0, db};
      S_RDRV:  return rdrv[idx];
      S_RDA:   return {2'd0, rda};
      S_RDB:   return {2'd0, rdb};
      S_RN:    return {9'd0, rn[idx]};
      default: return 16'hDEAD;
    endcase
  endfunction

  // Queue an expectation for the monitor, lat cycles from now.
  task automatic checkOutput(input string name, input int sig, input int idx,
                             input logic [15:0] exp, input int lat);
    exp_t e;
    e.due  = cyc + lat;
    e.name = name;
    e.sig  = sig;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Advance one cycle and drive the DAC-side inputs just after the edge.
  task automatic applyStimulus(input logic wrt, input logic dclk, input logic sel,
                               input logic drst, input logic [13:0] d0,
                               input logic [13:0] d1);
    @(posedge clk);
    #1;
    dac_wrt    = wrt;
    dac_clk    = dclk;
    dac_sel    = sel;
    dac_rst    = drst;
    dac_dat[0] = d0;
    dac_dat[1] = d1;
  endtask

  // Monitor: on each falling edge compare every expectation due this cycle.
  always @(negedge clk) begin
    int i;
    logic [15:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        act = actual(sb[i].sig, sb[i].idx);
        checkCount++;
        if (act === sb[i].exp) begin
          passCount++;
        end else begin
          $display("[TB] FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        checkCount++;
        $display("[TB] FAIL %s: stale expectation for cycle %0d", sb[i].name, sb[i].due);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    adc_rst = 1'b1;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    dac_dat = '0;
    dac_wrt = 1'b0; dac_sel = 1'b0; dac_clk = 1'b0; dac_rst = 1'b0;

    // Reset held: outputs cleared, n side all ones.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_drv0", S_DRV, 0, 16'h0000, 0);
    checkOutput("rst_drv3", S_DRV, 3, 16'h0000, 0);
    checkOutput("rst_n0", S_N, 0, 16'h007F, 0);
    checkOutput("rst_n3", S_N, 3, 16'h007F, 0);
    checkOutput("rst_ddr2", S_DDR, 2, 16'h0000, 0);
    checkOutput("rst_frame", S_FRAME, 0, 16'h0000, 0);
    checkOutput("rst_dac_a", S_DA, 0, 16'h0000, 0);
    checkOutput("rst_dac_b", S_DB, 0, 16'h0000, 0);
    checkOutput("rst_ramp_n1", S_RN, 1, 16'h007F, 0);

    // Release reset and present samples.
    @(posedge clk);
    #1;
    adc_rst = 1'b0;
    din0 = 14'h3C18;
    din1 = 14'h2AF3;
    din2 = 14'h1FFF;
    din3 = 14'h2000;
    checkOutput("par_ch0_m1000", S_DRV, 0, 16'hF060, 1);
    checkOutput("par_ch1", S_DRV, 1, 16'hABCC, 1);
    checkOutput("par_ch2_max", S_DRV, 2, 16'h7FFC, 1);
    checkOutput("par_ch3_min", S_DRV, 3, 16'h8000, 1);
    checkOutput("hw_first_frame", S_FRAME, 0, 16'h0001, 1);
    checkOutput("hw_first_ddr", S_DDR, 1, 16'h0000, 1);
    checkOutput("hw_ph0_ddr", S_DDR, 1, 16'h0073, 2);
    checkOutput("hw_ph0_p", S_P, 1, 16'h0073, 2);
    checkOutput("hw_ph0_n", S_N, 1, 16'h000C, 2);
    checkOutput("hw_ph0_frame", S_FRAME, 0, 16'h0000, 2);
    checkOutput("hw_ph1_ddr", S_DDR, 1, 16'h0055, 3);
    checkOutput("hw_ph1_p", S_P, 1, 16'h0055, 3);
    checkOutput("hw_ph1_n", S_N, 1, 16'h002A, 3);
    checkOutput("hw_ph1_frame", S_FRAME, 0, 16'h0001, 3);
    checkOutput("hw_ch3_ph1", S_DDR, 3, 16'h0040, 3);
    checkOutput("hw_ph0_again", S_DDR, 1, 16'h0073, 4);
    checkOutput("ramp0_first", S_RDRV, 0, lj(-1000), 1);
    checkOutput("ramp0_second", S_RDRV, 0, lj(-999), 2);
    checkOutput("ramp0_top", S_RDRV, 0, lj(1000), 2001);
    checkOutput("ramp0_wrap", S_RDRV, 0, lj(-1000), 2002);
    checkOutput("ramp0_after_wrap", S_RDRV, 0, lj(-999), 2003);
    checkOutput("ramp1_first", S_RDRV, 1, lj(-750), 1);
    checkOutput("ramp1_top", S_RDRV, 1, lj(1000), 1751);
    checkOutput("ramp1_wrap", S_RDRV, 1, lj(-1000), 1752);
    checkOutput("ramp3_first", S_RDRV, 3, lj(-250), 1);

    // DAC interleaved writes and parallel decode on the ramp instance.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14'h0123, 14'h0000);
    checkOutput("dac_a_write", S_DA, 0, 16'h2123, 1);
    checkOutput("par_dac_a", S_RDA, 0, 16'h2123, 1);
    checkOutput("par_dac_b", S_RDB, 0, 16'h2000, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14'h2000, 14'h0100);
    checkOutput("dac_a_zero", S_DA, 0, 16'h0000, 1);
    checkOutput("par_dac_b2", S_RDB, 0, 16'h2100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000, 14'h0100);
    checkOutput("dac_b_m8192", S_DB, 0, 16'h2000, 1);
    checkOutput("dac_a_hold", S_DA, 0, 16'h0000, 1);
    din0 = 14'd5;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 14'h3FFF, 14'h1000);
    checkOutput("par_ch0_5", S_DRV, 0, 16'h0014, 1);
    checkOutput("dac_clk_low_a", S_DA, 0, 16'h0000, 1);
    checkOutput("dac_clk_low_b", S_DB, 0, 16'h2000, 1);
    checkOutput("par_dac_ign_a", S_RDA, 0, 16'h1FFF, 1);
    checkOutput("par_dac_ign_b", S_RDB, 0, 16'h3000, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 14'h1111, 14'h1000);
    checkOutput("dac_no_wrt_b", S_DB, 0, 16'h2000, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 14'h1555, 14'h1555);
    checkOutput("dac_rst_a", S_DA, 0, 16'h0000, 1);
    checkOutput("dac_rst_b", S_DB, 0, 16'h0000, 1);
    checkOutput("par_dac_rst_a", S_RDA, 0, 16'h0000, 1);
    checkOutput("par_dac_rst_b", S_RDB, 0, 16'h0000, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14'h0001, 14'h0000);
    checkOutput("dac_a_rewrite", S_DA, 0, 16'h2001, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);

    // Let the ramp run past its wrap checks.
    repeat (2000) @(posedge clk);

    // Mid-stream reset and half-word restart.
    @(posedge clk);
    #1;
    adc_rst = 1'b1;
    checkOutput("mid_rst_drv0", S_DRV, 0, 16'h0000, 1);
    checkOutput("mid_rst_n1", S_N, 1, 16'h007F, 1);
    checkOutput("mid_rst_frame", S_FRAME, 0, 16'h0000, 1);
    checkOutput("mid_rst_dac_a", S_DA, 0, 16'h0000, 1);
    @(posedge clk);
    #1;
    adc_rst = 1'b0;
    checkOutput("mid_par_ch1", S_DRV, 1, 16'hABCC, 1);
    checkOutput("mid_first_frame", S_FRAME, 0, 16'h0001, 1);
    checkOutput("mid_first_ddr", S_DDR, 1, 16'h0000, 1);
    checkOutput("mid_ph0_ddr", S_DDR, 1, 16'h0073, 2);
    checkOutput("mid_ph1_ddr", S_DDR, 1, 16'h0055, 3);
    checkOutput("mid_ramp0", S_RDRV, 0, lj(-1000), 1);
    checkOutput("mid_ramp0_next", S_RDRV, 0, lj(-999), 2);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    foreach (sb[j]) begin
      checkCount++;
      $display("[TB] FAIL %s: never compared (due cycle %0d, now %0d)", sb[j].name, sb[j].due, cyc);
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
